// File: rtl/data_sync_mc_if.sv
// rtl/data_sync_mc_if.sv - source, consumer and status signals of data_sync_mc
// The source side is unsynchronized; the consumer side lives in the CLK domain.
interface data_sync_mc_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_CH    = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]           src_en;
  logic [NUM_CH*BUS_WIDTH-1:0] src_bus;
  logic                        out_ready;
  logic [NUM_CH-1:0]           ovr_clr;
  logic                        out_valid;
  logic [BUS_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]             out_ch;
  logic [NUM_CH-1:0]           cap_pulse;
  logic [NUM_CH-1:0]           ovr;

  modport master (
    output src_en, src_bus, out_ready, ovr_clr,
    input  out_valid, out_data, out_ch, cap_pulse, ovr
  );

  modport slave (
    input  src_en, src_bus, out_ready, ovr_clr,
    output out_valid, out_data, out_ch, cap_pulse, ovr
  );
endinterface

// File: rtl/data_sync_mc.sv
// rtl/data_sync_mc.sv - multi-channel enable-qualified data synchronizer
// Per-channel enable sync + capture into a one-deep holding slot, round-robin merge to one output.
module data_sync_mc #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int MODE       = 0
) (
  input logic           CLK,
  input logic           RST,
  data_sync_mc_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    sync_chain [NUM_STAGES];
  logic [NUM_CH-1:0]    sync;
  logic [NUM_CH-1:0]    prev;
  logic [NUM_CH-1:0]    edge_det;

  logic [BUS_WIDTH-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0]    pend;
  logic [NUM_CH-1:0]    pend_next;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      rr_next;

  logic                 out_valid_r;
  logic [BUS_WIDTH-1:0] out_data_r;
  logic [CH_W-1:0]      out_ch_r;
  logic [NUM_CH-1:0]    cap_pulse_r;
  logic [NUM_CH-1:0]    ovr_r;

  logic                 free;
  logic                 xfer;
  logic                 gnt_found;
  logic [CH_W-1:0]      gnt_idx;
  logic [CH_W-1:0]      cand;
  logic [NUM_CH-1:0]    cap_ok;
  logic [NUM_CH-1:0]    ovr_set;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        sync_chain[s] <= '0;
      end
      prev <= '0;
    end else begin
      sync_chain[0] <= bus.src_en;
      for (int s = 1; s < NUM_STAGES; s++) begin
        sync_chain[s] <= sync_chain[s-1];
      end
      prev <= sync;
    end
  end

  assign sync     = sync_chain[NUM_STAGES-1];
  assign edge_det = (MODE == 0) ? (sync & ~prev) : (sync ^ prev);

  assign free = ~out_valid_r | bus.out_ready;

  // First pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!gnt_found && pend[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign xfer    = free & gnt_found;
  assign rr_next = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // A slot being drained this cycle can take the new word at the same edge.
  always_comb begin
    cap_ok  = '0;
    ovr_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (edge_det[i]) begin
        if (!pend[i] || (xfer && (gnt_idx == CH_W'(i)))) begin
          cap_ok[i] = 1'b1;
        end else begin
          ovr_set[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_next = pend;
    if (xfer) begin
      pend_next[gnt_idx] = 1'b0;
    end
    pend_next = pend_next | cap_ok;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hold[i] <= '0;
      end
      pend        <= '0;
      rr_ptr      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      cap_pulse_r <= '0;
      ovr_r       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_ok[i]) begin
          hold[i] <= bus.src_bus[i*BUS_WIDTH +: BUS_WIDTH];
        end
      end
      pend        <= pend_next;
      cap_pulse_r <= cap_ok;
      ovr_r       <= (ovr_r & ~bus.ovr_clr) | ovr_set;
      if (xfer) begin
        out_valid_r <= 1'b1;
        out_data_r  <= hold[gnt_idx];
        out_ch_r    <= gnt_idx;
        rr_ptr      <= rr_next;
      end else if (free) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.cap_pulse = cap_pulse_r;
  assign bus.ovr       = ovr_r;
endmodule

// File: tb/tb_data_sync_mc.sv
// tb/tb_data_sync_mc.sv - bench for data_sync_mc, MODE=0 and MODE=1 instances side by side
// Both instances share stimulus; a queue-based model predicts every cycle of both.
module tb_data_sync_mc;
  localparam int NS = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  src_en = '0;
  logic [31:0] src_bus = '0;
  logic        out_ready = 1'b1;
  logic [3:0]  ovr_clr = '0;

  always #5 CLK = ~CLK;

  data_sync_mc_if #(.BUS_WIDTH(8), .NUM_CH(4)) b0 ();
  data_sync_mc_if #(.BUS_WIDTH(8), .NUM_CH(4)) b1 ();

  assign b0.src_en    = src_en;
  assign b0.src_bus   = src_bus;
  assign b0.out_ready = out_ready;
  assign b0.ovr_clr   = ovr_clr;
  assign b1.src_en    = src_en;
  assign b1.src_bus   = src_bus;
  assign b1.out_ready = out_ready;
  assign b1.ovr_clr   = ovr_clr;

  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(8), .NUM_CH(4), .MODE(0)) u0 (
    .CLK(CLK), .RST(RST), .bus(b0.slave));
  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(8), .NUM_CH(4), .MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .bus(b1.slave));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int cap0 [4];
  int cap1 [4];
  logic [9:0] words0 [$];
  logic [9:0] words1 [$];
  int wcyc0 [$];

  logic [3:0] eq [$];
  bit         mpend [2][4];
  logic [7:0] mhold [2][4];
  bit         mv [2];
  logic [7:0] md [2];
  int         mch [2];
  int         mrr [2];
  logic [3:0] mcap [2];
  logic [3:0] movr [2];

  typedef struct {
    logic [3:0]  en;
    logic [31:0] bus;
    logic        rdy;
    logic [3:0]  clr;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  ch;
    logic [3:0]  cap;
    logic [3:0]  ovr;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    eq.delete();
    repeat (NS + 1) eq.push_back(4'h0);
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; md[d] = '0; mch[d] = 0; mrr[d] = 0; mcap[d] = '0; movr[d] = '0;
      for (int c = 0; c < 4; c++) begin
        mpend[d][c] = 1'b0;
        mhold[d][c] = '0;
      end
    end
  endtask

  // eq[0] is src_en seen at the previous edge; an event seen NS edges ago is captured now.
  task automatic model_step();
    if (!RST) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      bit free;
      int g;
      logic [3:0] ev;
      logic [3:0] nov;
      free = !mv[d] || out_ready;
      g = -1;
      if (free) begin
        for (int k = 0; k < 4; k++) begin
          int c = (mrr[d] + k) % 4;
          if (g < 0 && mpend[d][c]) g = c;
        end
      end
      for (int i = 0; i < 4; i++) begin
        logic sy, pv;
        sy = eq[NS-1][i];
        pv = eq[NS][i];
        ev[i] = (d == 0) ? (sy & ~pv) : (sy ^ pv);
      end
      if (g >= 0) begin
        md[d] = mhold[d][g]; mch[d] = g; mv[d] = 1'b1;
        mpend[d][g] = 1'b0; mrr[d] = (g + 1) % 4;
      end else if (free) begin
        mv[d] = 1'b0;
      end
      mcap[d] = '0;
      nov = '0;
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) begin
          if (!mpend[d][i]) begin
            mhold[d][i] = src_bus[8*i +: 8];
            mpend[d][i] = 1'b1;
            mcap[d][i] = 1'b1;
          end else begin
            nov[i] = 1'b1;
          end
        end
      end
      movr[d] = (movr[d] & ~ovr_clr) | nov;
    end
    eq.push_front(src_en);
    void'(eq.pop_back());
  endtask

  task automatic cmp_dut(input int d);
    logic v; logic [7:0] dd; logic [1:0] cc; logic [3:0] cp, ov;
    if (d == 0) begin
      v = b0.out_valid; dd = b0.out_data; cc = b0.out_ch; cp = b0.cap_pulse; ov = b0.ovr;
    end else begin
      v = b1.out_valid; dd = b1.out_data; cc = b1.out_ch; cp = b1.cap_pulse; ov = b1.ovr;
    end
    check($sformatf("u%0d out_valid cyc%0d", d, cyc), v, mv[d]);
    check($sformatf("u%0d out_data cyc%0d", d, cyc), dd, md[d]);
    check($sformatf("u%0d out_ch cyc%0d", d, cyc), cc, mch[d]);
    check($sformatf("u%0d cap_pulse cyc%0d", d, cyc), cp, mcap[d]);
    check($sformatf("u%0d ovr cyc%0d", d, cyc), ov, movr[d]);
  endtask

  // Records the handshake about to happen, advances one edge, then samples 1 ns later.
  task automatic step();
    if (b0.out_valid && out_ready) begin
      words0.push_back({b0.out_ch, b0.out_data});
      wcyc0.push_back(cyc);
    end
    if (b1.out_valid && out_ready) words1.push_back({b1.out_ch, b1.out_data});
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (b0.cap_pulse[c]) cap0[c]++;
      if (b1.cap_pulse[c]) cap1[c]++;
    end
    cmp_dut(0);
    cmp_dut(1);
  endtask

  task automatic clear_obs();
    words0.delete(); words1.delete(); wcyc0.delete();
    for (int c = 0; c < 4; c++) begin
      cap0[c] = 0;
      cap1[c] = 0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    repeat (2) step();
    RST = 1'b1;
    clear_obs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first0;
    tbl[0]  = '{4'h1, 32'h0000_00A5, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 32'h0000_00A5, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 32'h0000_00A5, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h1, 4'h0};
    tbl[3]  = '{4'h1, 32'h0000_00A5, 1'b1, 4'h0, 1'b1, 8'hA5, 2'd0, 4'h0, 4'h0};
    tbl[4]  = '{4'h0, 32'h0000_00A5, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 4'h0, 4'h0};
    tbl[5]  = '{4'h0, 32'h0000_00A5, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 4'h0, 4'h0};
    tbl[6]  = '{4'h8, 32'hC300_0000, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 4'h0, 4'h0};
    tbl[7]  = '{4'h8, 32'hC300_0000, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 4'h0, 4'h0};
    tbl[8]  = '{4'h8, 32'hC300_0000, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 4'h8, 4'h0};
    tbl[9]  = '{4'h8, 32'hC300_0000, 1'b1, 4'h0, 1'b1, 8'hC3, 2'd3, 4'h0, 4'h0};
    tbl[10] = '{4'h8, 32'hC300_0000, 1'b0, 4'h0, 1'b1, 8'hC3, 2'd3, 4'h0, 4'h0};
    tbl[11] = '{4'h8, 32'hC300_0000, 1'b0, 4'h0, 1'b1, 8'hC3, 2'd3, 4'h0, 4'h0};
    tbl[12] = '{4'h8, 32'hC300_0000, 1'b1, 4'h0, 1'b0, 8'hC3, 2'd3, 4'h0, 4'h0};
    tbl[13] = '{4'h0, 32'hC300_0000, 1'b1, 4'h0, 1'b0, 8'hC3, 2'd3, 4'h0, 4'h0};

    model_reset();
    do_reset();
    check("rst out_valid", b0.out_valid, 1'b0);
    check("rst out_data", b0.out_data, 8'h00);
    check("rst cap_pulse", b0.cap_pulse, 4'h0);
    check("rst ovr", b0.ovr, 4'h0);

    foreach (tbl[r]) begin
      src_en = tbl[r].en; src_bus = tbl[r].bus; out_ready = tbl[r].rdy; ovr_clr = tbl[r].clr;
      step();
      check($sformatf("tbl%0d out_valid", r), b0.out_valid, tbl[r].v);
      check($sformatf("tbl%0d out_data", r), b0.out_data, tbl[r].d);
      check($sformatf("tbl%0d out_ch", r), b0.out_ch, tbl[r].ch);
      check($sformatf("tbl%0d cap_pulse", r), b0.cap_pulse, tbl[r].cap);
      check($sformatf("tbl%0d ovr", r), b0.ovr, tbl[r].ovr);
    end

    // Toggle protocol: both edges of src_en[2] deliver a word.
    src_en = '0; out_ready = 1'b1; ovr_clr = '0;
    do_reset();
    src_en = 4'b0100; src_bus = 32'h0011_0000;
    repeat (10) step();
    src_en = 4'b0000; src_bus = 32'h0022_0000;
    repeat (10) step();
    check("toggle word count", words1.size(), 2);
    if (words1.size() == 2) begin
      check("toggle word0", words1[0], {2'd2, 8'h11});
      check("toggle word1", words1[1], {2'd2, 8'h22});
    end

    // All channels fire together: drained in channel order, one per cycle.
    src_en = '0;
    do_reset();
    src_en = 4'hF; src_bus = 32'h4030_2010;
    repeat (8) step();
    check("rr word count", words0.size(), 4);
    for (int i = 0; i < words0.size(); i++) begin
      check($sformatf("rr word%0d", i), words0[i], {2'(i), 8'((i + 1) * 16)});
      if (i > 0) check($sformatf("rr gap%0d", i), wcyc0[i] - wcyc0[i-1], 1);
    end
    check("rr_ptr wrapped", u0.rr_ptr, 2'd0);

    // Stalled output, second word parked, third word overruns.
    src_en = '0;
    do_reset();
    out_ready = 1'b0;
    src_en = 4'b0010; src_bus = 32'h0000_5500;
    repeat (4) step();
    check("stall first out_valid", b0.out_valid, 1'b1);
    check("stall first out_data", b0.out_data, 8'h55);
    src_en = 4'b0000; repeat (2) step();
    src_en = 4'b0010; src_bus = 32'h0000_6600; repeat (4) step();
    check("stall second captured", cap0[1], 2);
    check("stall second no ovr", b0.ovr, 4'h0);
    src_en = 4'b0000; repeat (2) step();
    src_en = 4'b0010; src_bus = 32'h0000_7700; repeat (4) step();
    check("stall ovr set", b0.ovr, 4'b0010);
    check("stall out_data held", b0.out_data, 8'h55);
    check("stall third not captured", cap0[1], 2);
    ovr_clr = 4'b0010; step(); ovr_clr = 4'b0000;
    check("ovr cleared", b0.ovr[1], 1'b0);
    words0.delete();
    out_ready = 1'b1;
    repeat (4) step();
    check("stall drained count", words0.size(), 2);
    if (words0.size() == 2) begin
      check("stall drained word0", words0[0], {2'd1, 8'h55});
      check("stall drained word1", words0[1], {2'd1, 8'h66});
    end

    // Asynchronous reset with every slot full and the output stalled.
    src_en = '0;
    do_reset();
    out_ready = 1'b0;
    src_en = 4'hF; src_bus = 32'h4433_2211;
    repeat (4) step();
    src_en = 4'h0; step();
    src_en = 4'h1; repeat (3) step();
    check("pre-reset pend full", u0.pend, 4'hF);
    check("pre-reset out_valid", b0.out_valid, 1'b1);
    RST = 1'b0;
    model_reset();
    #1;
    check("async rst out_valid u0", b0.out_valid, 1'b0);
    check("async rst out_data u0", b0.out_data, 8'h00);
    check("async rst out_ch u0", b0.out_ch, 2'd0);
    check("async rst cap_pulse u0", b0.cap_pulse, 4'h0);
    check("async rst ovr u0", b0.ovr, 4'h0);
    check("async rst out_valid u1", b1.out_valid, 1'b0);
    src_en = 4'h0;
    repeat (2) step();
    RST = 1'b1;
    out_ready = 1'b1;
    clear_obs();
    repeat (10) step();
    check("post-reset no words u0", words0.size(), 0);
    check("post-reset no words u1", words1.size(), 0);
    check("post-reset no caps", cap0[0] + cap0[1] + cap0[2] + cap0[3] + cap1[0] + cap1[1] + cap1[2] + cap1[3], 0);

    // Level held high for 50 cycles.
    do_reset();
    src_en = 4'b1000; src_bus = 32'h9900_0000;
    repeat (50) step();
    src_en = 4'b0000;
    repeat (5) step();
    check("held level one cap", cap0[3], 1);
    check("held level one word", words0.size(), 1);
    check("held level toggle caps", cap1[3], 2);

    // Enable already high when reset is released.
    RST = 1'b0;
    model_reset();
    src_en = 4'b0001; src_bus = 32'h0000_00A5; out_ready = 1'b1;
    repeat (2) step();
    RST = 1'b1;
    clear_obs();
    first0 = -1;
    for (int t = 1; t <= 8; t++) begin
      step();
      if (b0.cap_pulse[0] && first0 < 0) first0 = t;
    end
    check("release capture edge", first0, 3);
    check("release single cap u0", cap0[0], 1);
    check("release single cap u1", cap1[0], 1);

    // Randomized traffic against the model.
    src_en = '0;
    do_reset();
    repeat (1500) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(5) == 0) src_en[c] = ~src_en[c];
      end
      src_bus = $urandom;
      out_ready = ($urandom_range(9) < 7);
      ovr_clr = ($urandom_range(9) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
